// File: rtl/scan_sequencer_pkg.sv
// scan_sequencer_pkg: shared widths, default grid/settle constants and FSM state encodings for the scan sequencer
package scan_sequencer_pkg;
  localparam int ADC_W = 12;
  localparam int PW_W = 32;
  localparam int PW_MIN_D = 5000;
  localparam int PW_MAX_D = 25000;
  localparam int PW_STEP_D = 1000;
  localparam int SETTLE_CYC_D = 1000000;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_STEP = 3'd4;
  localparam logic [2:0] S_PARK = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;
endpackage

// File: rtl/scan_sequencer_if.sv
// scan_sequencer_if: ADC handshake, max-register link and servo command bundle; master is the sequencer side
interface scan_sequencer_if;
  import scan_sequencer_pkg::*;
  logic start;
  logic adc_req;
  logic adc_valid;
  logic [ADC_W-1:0] adc_data;
  logic [ADC_W-1:0] lv;
  logic [ADC_W-1:0] pv;
  logic gt;
  logic [PW_W-1:0] pulse_max_h;
  logic [PW_W-1:0] pulse_max_v;
  logic [PW_W-1:0] pulse_h;
  logic [PW_W-1:0] pulse_v;
  logic busy;
  logic done;
  modport master (
    input start, adc_valid, adc_data, lv, pulse_max_h, pulse_max_v,
    output adc_req, pv, gt, pulse_h, pulse_v, busy, done
  );
  modport slave (
    output start, adc_valid, adc_data, lv, pulse_max_h, pulse_max_v,
    input adc_req, pv, gt, pulse_h, pulse_v, busy, done
  );
endinterface

// File: rtl/scan_sequencer_settle_timer.sv
// settle_timer: loadable down-counter; expire pulses on the last of max(CYC,1) counted cycles, run while counting
module settle_timer #(
  parameter int CYC = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  output logic expire,
  output logic run
);
  localparam int N = (CYC < 1) ? 1 : CYC;
  logic [31:0] cnt;
  assign expire = cnt == 32'd1;
  assign run = cnt != 32'd0;
  // load restarts the count; otherwise count down to zero and stop
  always_ff @(posedge CLK)
    if (RST) cnt <= '0;
    else if (load) cnt <= 32'(N);
    else if (run) cnt <= cnt - 32'd1;
endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: raster-scan servo sweep with settle, ADC sample and max compare, then park at best; SCAN_HYSTERESIS_EN adds HYST margin
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int PW_MIN = PW_MIN_D,
  parameter int PW_MAX = PW_MAX_D,
  parameter int PW_STEP = PW_STEP_D,
`ifdef SCAN_HYSTERESIS_EN
  parameter int HYST = 8,
`endif
  parameter int SETTLE_CYC = SETTLE_CYC_D
) (
  input logic CLK,
  input logic RST,
  scan_sequencer_if.master bus
);
  logic [2:0] state;
  logic first;
  logic load;
  logic expire;
  logic run;
  logic win;
  logic h_ok;
  logic v_ok;
  settle_timer #(.CYC(SETTLE_CYC)) u_timer (
    .CLK(CLK),
    .RST(RST),
    .load(load),
    .expire(expire),
    .run(run)
  );
`ifdef SCAN_HYSTERESIS_EN
  assign win = {1'b0, bus.pv} > ({1'b0, bus.lv} + (ADC_W+1)'(HYST));
`else
  assign win = bus.pv > bus.lv;
`endif
  assign h_ok = ({1'b0, bus.pulse_h} + 33'(PW_STEP)) <= 33'(PW_MAX);
  assign v_ok = ({1'b0, bus.pulse_v} + 33'(PW_STEP)) <= 33'(PW_MAX);
  assign load = (state == S_IDLE && bus.start) || (state == S_STEP && (h_ok || v_ok)) || (state == S_PARK && !run);
  assign bus.gt = state == S_COMPARE && (first || win);
  assign bus.busy = state != S_IDLE;
  assign bus.done = state == S_FINISH;
  // scan FSM: positions and sample only change outside COMPARE so the register latches a consistent set
  always_ff @(posedge CLK)
    if (RST) begin
      state <= S_IDLE;
      bus.pulse_h <= PW_W'(PW_MIN);
      bus.pulse_v <= PW_W'(PW_MIN);
      bus.pv <= '0;
      bus.adc_req <= 1'b0;
      first <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          bus.pulse_h <= PW_W'(PW_MIN);
          bus.pulse_v <= PW_W'(PW_MIN);
          first <= 1'b1;
          state <= S_SETTLE;
        end
        S_SETTLE: if (expire) begin
          bus.adc_req <= 1'b1;
          state <= S_SAMPLE;
        end
        S_SAMPLE: if (bus.adc_req && bus.adc_valid) begin
          bus.pv <= bus.adc_data;
          bus.adc_req <= 1'b0;
          state <= S_COMPARE;
        end
        S_COMPARE: begin
          first <= 1'b0;
          state <= S_STEP;
        end
        S_STEP: if (h_ok) begin
          bus.pulse_h <= bus.pulse_h + PW_W'(PW_STEP);
          state <= S_SETTLE;
        end else if (v_ok) begin
          bus.pulse_h <= PW_W'(PW_MIN);
          bus.pulse_v <= bus.pulse_v + PW_W'(PW_STEP);
          state <= S_SETTLE;
        end else state <= S_PARK;
        S_PARK: if (!run) begin
          bus.pulse_h <= bus.pulse_max_h;
          bus.pulse_v <= bus.pulse_max_v;
        end else if (expire) state <= S_FINISH;
        S_FINISH: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: table-driven scan vectors on a 3x3 grid plus hand-written reset and park-timing sequences
module tb_scan_sequencer;
  import scan_sequencer_pkg::*;
  localparam int N = 4;
  typedef struct {
    logic [11:0] adc;
    logic [11:0] lv;
    logic fb;
    logic gt;
  } vec_t;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic fb = 1'b0;
  logic [11:0] lv_drv = '0;
  logic [11:0] m_lv = '0;
  logic [31:0] m_h = 32'd5000;
  logic [31:0] m_v = 32'd5000;
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  vec_t vec[36];
  int park_h[4];
  int park_v[4];
  scan_sequencer_if bus();
  scan_sequencer #(.PW_MIN(5000), .PW_MAX(7000), .PW_STEP(1000), .SETTLE_CYC(N)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.master)
  );
  always #5 CLK = ~CLK;
  assign bus.lv = fb ? m_lv : lv_drv;
  assign bus.pulse_max_h = m_h;
  assign bus.pulse_max_v = m_v;
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (bus.gt) begin
      m_lv <= bus.pv;
      m_h <= bus.pulse_h;
      m_v <= bus.pulse_v;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_scan(input int s, input logic f, input int a[9], input int l[9], input int g[9], input int ph, input int pv_);
    for (int p = 0; p < 9; p++) begin
      vec[s*9+p].adc = 12'(a[p]);
      vec[s*9+p].lv = 12'(l[p]);
      vec[s*9+p].fb = f;
      vec[s*9+p].gt = g[p][0];
    end
    park_h[s] = ph;
    park_v[s] = pv_;
  endtask

  task automatic run_scan(input int s, input bit hold);
    int c;
    int t;
    int b;
    b = s * 9;
    c = 0;
    @(negedge CLK);
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    for (int p = 0; p < 9; p++) begin
      fb = vec[b+p].fb;
      lv_drv = vec[b+p].lv;
      if (hold) begin
        bus.adc_valid = 1'b1;
        bus.adc_data = vec[b+p].adc;
      end
      t = 0;
      while (!bus.adc_req && t < 100) begin
        @(negedge CLK);
        t++;
      end
      chk("req_seen", 32'(bus.adc_req), 32'd1);
      if (!hold) begin
        repeat (3) @(negedge CLK);
        chk("req_held", 32'(bus.adc_req), 32'd1);
        bus.adc_data = vec[b+p].adc;
        bus.adc_valid = 1'b1;
      end
      @(negedge CLK);
      c = cyc;
      bus.adc_valid = hold;
      if (hold) bus.adc_data = ~vec[b+p].adc;
      chk($sformatf("gt s%0d p%0d", s, p), 32'(bus.gt), 32'(vec[b+p].gt));
      chk($sformatf("pv s%0d p%0d", s, p), 32'(bus.pv), 32'(vec[b+p].adc));
      chk($sformatf("h s%0d p%0d", s, p), bus.pulse_h, 32'(5000 + 1000 * (p % 3)));
      chk($sformatf("v s%0d p%0d", s, p), bus.pulse_v, 32'(5000 + 1000 * (p / 3)));
      chk("req_drop", 32'(bus.adc_req), 32'd0);
      if (s == 1 && p == 4) bus.start = 1'b1;
      @(negedge CLK);
      bus.start = 1'b0;
      chk("gt_one_cycle", 32'(bus.gt), 32'd0);
      if (hold && p < 8) begin
        @(negedge CLK);
        chk("pv_spurious", 32'(bus.pv), 32'(vec[b+p].adc));
      end
    end
    bus.adc_valid = 1'b0;
    t = 0;
    while (!bus.done && t < 100) begin
      @(negedge CLK);
      t++;
    end
    chk("done_seen", 32'(bus.done), 32'd1);
    chk("done_after_park", 32'(cyc - (c + 2)), 32'(N + 1));
    chk("park_h", bus.pulse_h, 32'(park_h[s]));
    chk("park_v", bus.pulse_v, 32'(park_v[s]));
    @(negedge CLK);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_park_h", bus.pulse_h, 32'(park_h[s]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
    $fatal(1);
  end

  initial begin
    int t;
    bit seen;
    bus.start = 1'b0;
    bus.adc_valid = 1'b0;
    bus.adc_data = '0;
    set_scan(0, 1'b1, '{100, 300, 200, 150, 250, 50, 10, 299, 300}, '{0, 0, 0, 0, 0, 0, 0, 0, 0},
             '{1, 1, 0, 0, 0, 0, 0, 0, 0}, 6000, 5000);
    set_scan(1, 1'b1, '{10, 20, 30, 40, 50, 60, 70, 4095, 80}, '{0, 0, 0, 0, 0, 0, 0, 0, 0},
             '{1, 1, 1, 1, 1, 1, 1, 1, 0}, 6000, 7000);
    set_scan(2, 1'b1, '{5, 5, 5, 5, 5, 5, 5, 5, 5}, '{0, 0, 0, 0, 0, 0, 0, 0, 0},
             '{1, 0, 0, 0, 0, 0, 0, 0, 0}, 5000, 5000);
`ifdef SCAN_HYSTERESIS_EN
    set_scan(3, 1'b0, '{0, 108, 109, 4095, 0, 9, 8, 4095, 4095}, '{4095, 100, 100, 4095, 0, 0, 0, 4086, 4087},
             '{1, 0, 1, 0, 0, 1, 0, 1, 0}, 6000, 7000);
`else
    set_scan(3, 1'b0, '{0, 100, 101, 4095, 0, 1, 4095, 2000, 2001}, '{4095, 100, 100, 4095, 0, 0, 4094, 2001, 2000},
             '{1, 0, 1, 0, 0, 1, 1, 0, 1}, 7000, 7000);
`endif
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_gt", 32'(bus.gt), 32'd0);
    chk("rst_req", 32'(bus.adc_req), 32'd0);
    chk("rst_pv", 32'(bus.pv), 32'd0);
    chk("rst_h", bus.pulse_h, 32'd5000);
    chk("rst_v", bus.pulse_v, 32'd5000);
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    t = 0;
    while (!bus.adc_req && t < 100) begin
      @(negedge CLK);
      t++;
    end
    chk("abort_req", 32'(bus.adc_req), 32'd1);
    bus.adc_data = 12'd777;
    bus.adc_valid = 1'b1;
    @(negedge CLK);
    bus.adc_valid = 1'b0;
    chk("abort_pv", 32'(bus.pv), 32'd777);
    repeat (2) @(negedge CLK);
    chk("abort_h_moved", bus.pulse_h, 32'd6000);
    chk("abort_busy", 32'(bus.busy), 32'd1);
    RST = 1'b1;
    bus.start = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    bus.start = 1'b0;
    chk("abort_idle", 32'(bus.busy), 32'd0);
    chk("abort_h", bus.pulse_h, 32'd5000);
    chk("abort_v", bus.pulse_v, 32'd5000);
    chk("abort_pv0", 32'(bus.pv), 32'd0);
    chk("abort_gt", 32'(bus.gt), 32'd0);
    chk("abort_req0", 32'(bus.adc_req), 32'd0);
    seen = 1'b0;
    bus.adc_valid = 1'b1;
    repeat (N + 6) begin
      @(negedge CLK);
      seen = seen | bus.done | bus.busy;
    end
    bus.adc_valid = 1'b0;
    chk("abort_no_done", 32'(seen), 32'd0);
    chk("idle_valid_pv", 32'(bus.pv), 32'd0);
    run_scan(0, 1'b0);
    run_scan(1, 1'b1);
    chk("stale_lv", 32'(m_lv), 32'd4095);
    run_scan(2, 1'b0);
    run_scan(3, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
